// File: rtl/sobel_row_window.sv
// -----------------------------------------------------------------------------
// sobel_row_window
//
// Purpose:
//   Three-row sliding window in front of the Sobel accelerator cores. One
//   image-row word is accepted per input handshake. The last three rows are
//   presented as row1 (oldest), row2 and row3 (newest) with a valid/ready
//   handshake. The block counts rows within a column strip and flags the
//   final window of each strip with out_last.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   Once valid is raised, the producer holds valid and data stable until the
//   transfer. ready may depend on valid. On the input side,
//   in_ready = !out_valid || out_ready, so a held window blocks new rows.
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   cfg_rows      rows per strip, latched on each accepted in_first row
//   in_valid      in_data/in_first are valid
//   in_ready      block accepts a row this cycle (combinational)
//   in_data       one row word, byte 0 = rightmost pixel
//   in_first      row is the first row of a new strip
//   out_valid     row1/2/3_data hold a valid window
//   out_ready     downstream consumes the window
//   row1_data     oldest row
//   row2_data     middle row
//   row3_data     newest row
//   out_last      window is the final window of the strip
//   dbg_state     fill state (0 = EMPTY, 1 = ONE, 2 = TWO, 3 = FULL)
//   stall_count   cycles with out_valid && !out_ready, saturating
//                 (present only when SOBEL_WINDOW_STALL_CNT_EN is defined)
//
// Build option:
//   SOBEL_WINDOW_STALL_CNT_EN  adds the stall_count output and its counter.
// -----------------------------------------------------------------------------
module sobel_row_window #(
  parameter int NUM_ACC = 8,
  parameter int IW      = (NUM_ACC + 2) * 8,
  parameter int ROWW    = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWW-1:0] cfg_rows,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_data,
  input  logic            in_first,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   row1_data,
  output logic [IW-1:0]   row2_data,
  output logic [IW-1:0]   row3_data,
  output logic            out_last,
  output logic [1:0]      dbg_state
`ifdef SOBEL_WINDOW_STALL_CNT_EN
  ,
  output logic [15:0]     stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } state_t;

  localparam logic [ROWW-1:0] CNT_ONE = ROWW'(1);
  localparam logic [ROWW-1:0] CNT_MAX = {ROWW{1'b1}};
  localparam logic [ROWW-1:0] CFG_MIN = ROWW'(3);

  state_t          r_state;
  logic [IW-1:0]   r_row1;
  logic [IW-1:0]   r_row2;
  logic [IW-1:0]   r_row3;
  logic            r_out_valid;
  logic            r_out_last;
  logic [ROWW-1:0] r_row_cnt;
  logic [ROWW-1:0] r_cfg_rows;

  state_t          w_state_nxt;
  logic [IW-1:0]   w_row1_nxt;
  logic [IW-1:0]   w_row2_nxt;
  logic [IW-1:0]   w_row3_nxt;
  logic            w_out_valid_nxt;
  logic            w_out_last_nxt;
  logic [ROWW-1:0] w_row_cnt_nxt;
  logic [ROWW-1:0] w_cfg_rows_nxt;
  logic            w_accept;
  logic            w_consume;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_out_valid && out_ready;

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign row1_data = r_row1;
  assign row2_data = r_row2;
  assign row3_data = r_row3;
  assign dbg_state = r_state;

  always_comb begin
    w_state_nxt     = r_state;
    w_row1_nxt      = r_row1;
    w_row2_nxt      = r_row2;
    w_row3_nxt      = r_row3;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_row_cnt_nxt   = r_row_cnt;
    w_cfg_rows_nxt  = r_cfg_rows;

    if (w_accept && in_first) begin
      // New strip: drop the old rows and any window not yet consumed.
      w_state_nxt     = ONE;
      w_row1_nxt      = '0;
      w_row2_nxt      = '0;
      w_row3_nxt      = in_data;
      w_out_valid_nxt = 1'b0;
      w_out_last_nxt  = 1'b0;
      w_row_cnt_nxt   = CNT_ONE;
      w_cfg_rows_nxt  = cfg_rows;
    end else if (w_accept) begin
      w_row1_nxt = r_row2;
      w_row2_nxt = r_row3;
      w_row3_nxt = in_data;
      unique case (r_state)
        EMPTY:   w_state_nxt = ONE;
        ONE:     w_state_nxt = TWO;
        default: w_state_nxt = FULL;
      endcase
      w_row_cnt_nxt = (r_row_cnt == CNT_MAX) ? r_row_cnt : r_row_cnt + CNT_ONE;
      // Strips shorter than three rows never yield a window.
      w_out_valid_nxt = (w_state_nxt == FULL) && (r_cfg_rows >= CFG_MIN);
      w_out_last_nxt  = w_out_valid_nxt && (w_row_cnt_nxt == r_cfg_rows);
    end else if (w_consume) begin
      // Rows are kept, but the same window is not presented twice.
      w_out_valid_nxt = 1'b0;
      w_out_last_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_row1      <= '0;
      r_row2      <= '0;
      r_row3      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_row_cnt   <= '0;
      r_cfg_rows  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_row1      <= w_row1_nxt;
      r_row2      <= w_row2_nxt;
      r_row3      <= w_row3_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_row_cnt   <= w_row_cnt_nxt;
      r_cfg_rows  <= w_cfg_rows_nxt;
    end
  end

`ifdef SOBEL_WINDOW_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  assign stall_count = r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_accept && in_first) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_row_window.sv
// -----------------------------------------------------------------------------
// tb_sobel_row_window
//
// Directed bench for sobel_row_window with NUM_ACC = 8 (80-bit rows).
// Inputs change 1 ns after a rising edge; outputs are checked at that same
// point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_sobel_row_window;

  localparam int NUM_ACC = 8;
  localparam int IW      = (NUM_ACC + 2) * 8;
  localparam int ROWW    = 10;

  logic            clk;
  logic            reset;
  logic [ROWW-1:0] cfg_rows;
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   in_data;
  logic            in_first;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   row1_data;
  logic [IW-1:0]   row2_data;
  logic [IW-1:0]   row3_data;
  logic            out_last;
  logic [1:0]      dbg_state;
`ifdef SOBEL_WINDOW_STALL_CNT_EN
  logic [15:0]     stall_count;
`endif

  int checks;
  int errors;

  logic [IW-1:0] ra, rb, rc, rd, re, rx, ry, rz, s1, s2, s3, p1, p2, p3, p4;

  sobel_row_window #(
    .NUM_ACC(NUM_ACC),
    .IW     (IW),
    .ROWW   (ROWW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_rows (cfg_rows),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_first (in_first),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .row1_data(row1_data),
    .row2_data(row2_data),
    .row3_data(row3_data),
    .out_last (out_last),
    .dbg_state(dbg_state)
`ifdef SOBEL_WINDOW_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic send_row(input logic [IW-1:0] d, input logic f);
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    @(posedge clk);
    #1;
    in_first = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_first = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1; cfg_rows = '0; in_valid = 1'b0; in_data = '0;
    in_first = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if ({row1_data, row2_data, row3_data} !== {3*IW{1'b0}}) begin errors++; $display("FAIL reset_rows got %h exp 0", {row1_data, row2_data, row3_data}); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", out_last); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
`ifdef SOBEL_WINDOW_STALL_CNT_EN
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_count); end
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_prime();
    cfg_rows = 10'd5; out_ready = 1'b1;
    send_row(ra, 1'b1);
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL prime_state_one got %0d exp 1", dbg_state); end
    checks++; if ({row1_data, row2_data, row3_data} !== {{2*IW{1'b0}}, ra}) begin errors++; $display("FAIL prime_first_rows got %h", {row1_data, row2_data, row3_data}); end
    send_row(rb, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prime_valid_two got %b exp 0", out_valid); end
    send_row(rc, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL prime_valid got %b exp 1", out_valid); end
    checks++; if ({row1_data, row2_data, row3_data} !== {ra, rb, rc}) begin errors++; $display("FAIL prime_window got %h", {row1_data, row2_data, row3_data}); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL prime_last got %b exp 0", out_last); end
  endtask

  task automatic test_streaming();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_d got %b exp 1", in_ready); end
    send_row(rd, 1'b0);
    checks++; if ({out_valid, out_last} !== 2'b10) begin errors++; $display("FAIL stream_bcd_flags got %b exp 10", {out_valid, out_last}); end
    checks++; if ({row1_data, row2_data, row3_data} !== {rb, rc, rd}) begin errors++; $display("FAIL stream_bcd got %h", {row1_data, row2_data, row3_data}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_e got %b exp 1", in_ready); end
    send_row(re, 1'b0);
    checks++; if ({out_valid, out_last} !== 2'b11) begin errors++; $display("FAIL stream_cde_flags got %b exp 11", {out_valid, out_last}); end
    checks++; if ({row1_data, row2_data, row3_data} !== {rc, rd, re}) begin errors++; $display("FAIL stream_cde got %h", {row1_data, row2_data, row3_data}); end
    idle_cycle();
    checks++; if ({out_valid, out_last} !== 2'b00) begin errors++; $display("FAIL stream_drain got %b exp 00", {out_valid, out_last}); end
    checks++; if ({row1_data, row2_data, row3_data} !== {rc, rd, re}) begin errors++; $display("FAIL stream_hold got %h", {row1_data, row2_data, row3_data}); end
  endtask

  task automatic test_backpressure();
    cfg_rows = 10'd5; out_ready = 1'b0;
    send_row(ra, 1'b1);
    send_row(rb, 1'b0);
    send_row(rc, 1'b0);
    in_valid = 1'b1; in_data = rd;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
      checks++; if ({out_valid, row1_data, row2_data, row3_data} !== {1'b1, ra, rb, rc}) begin errors++; $display("FAIL bp_hold[%0d] got %h", i, {row1_data, row2_data, row3_data}); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    @(posedge clk);
    #1;
    checks++; if ({out_valid, row1_data, row2_data, row3_data} !== {1'b1, rb, rc, rd}) begin errors++; $display("FAIL bp_bcd got %h", {row1_data, row2_data, row3_data}); end
`ifdef SOBEL_WINDOW_STALL_CNT_EN
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL bp_stall got %0d exp 3", stall_count); end
`endif
  endtask

  task automatic test_restart();
    // Window (B,C,D) is still valid when X arrives as a new strip.
    send_row(rx, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL restart_valid got %b exp 0", out_valid); end
    checks++; if ({row1_data, row2_data, row3_data} !== {{2*IW{1'b0}}, rx}) begin errors++; $display("FAIL restart_rows got %h", {row1_data, row2_data, row3_data}); end
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL restart_state got %0d exp 1", dbg_state); end
`ifdef SOBEL_WINDOW_STALL_CNT_EN
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL restart_stall got %0d exp 0", stall_count); end
`endif
    send_row(ry, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL restart_y_valid got %b exp 0", out_valid); end
    send_row(rz, 1'b0);
    checks++; if ({out_valid, row1_data, row2_data, row3_data} !== {1'b1, rx, ry, rz}) begin errors++; $display("FAIL restart_xyz got %b %h", out_valid, {row1_data, row2_data, row3_data}); end
    idle_cycle();
  endtask

  task automatic test_short_strip();
    cfg_rows = 10'd2;
    send_row(s1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL short_s1 got %b exp 0", out_valid); end
    send_row(s2, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL short_s2 got %b exp 0", out_valid); end
    send_row(s3, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL short_s3 got %b exp 0", out_valid); end
    checks++; if ({row1_data, row2_data, row3_data} !== {s1, s2, s3}) begin errors++; $display("FAIL short_shift got %h", {row1_data, row2_data, row3_data}); end
    idle_cycle();
  endtask

  task automatic test_beyond_cfg();
    cfg_rows = 10'd3;
    send_row(p1, 1'b1);
    send_row(p2, 1'b0);
    send_row(p3, 1'b0);
    checks++; if ({out_valid, out_last} !== 2'b11) begin errors++; $display("FAIL beyond_last_flags got %b exp 11", {out_valid, out_last}); end
    send_row(p4, 1'b0);
    checks++; if ({out_valid, out_last} !== 2'b10) begin errors++; $display("FAIL beyond_extra_flags got %b exp 10", {out_valid, out_last}); end
    checks++; if ({row1_data, row2_data, row3_data} !== {p2, p3, p4}) begin errors++; $display("FAIL beyond_extra_rows got %h", {row1_data, row2_data, row3_data}); end
    idle_cycle();
  endtask

  task automatic test_async_reset();
    cfg_rows = 10'd3; out_ready = 1'b0;
    send_row(ra, 1'b1);
    send_row(rb, 1'b0);
    send_row(rc, 1'b0);
    in_valid = 1'b0;
    checks++; if ({out_valid, out_last} !== 2'b11) begin errors++; $display("FAIL areset_pre got %b exp 11", {out_valid, out_last}); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({out_valid, out_last} !== 2'b00) begin errors++; $display("FAIL areset_flags got %b exp 00", {out_valid, out_last}); end
    checks++; if ({row1_data, row2_data, row3_data} !== {3*IW{1'b0}}) begin errors++; $display("FAIL areset_rows got %h exp 0", {row1_data, row2_data, row3_data}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got %b exp 1", in_ready); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL areset_state got %0d exp 0", dbg_state); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ra = {10{8'hA1}}; rb = {10{8'hB2}}; rc = {10{8'hC3}}; rd = {10{8'hD4}};
    re = {10{8'hE5}}; rx = {10{8'h5A}}; ry = {10{8'h6B}}; rz = {10{8'h7C}};
    s1 = 80'h0102030405060708090A; s2 = 80'h1112131415161718191A;
    s3 = 80'h2122232425262728292A; p1 = {10{8'h11}}; p2 = {10{8'h22}};
    p3 = {10{8'h33}}; p4 = {10{8'h44}};

    test_reset();
    test_prime();
    test_streaming();
    test_backpressure();
    test_restart();
    test_short_strip();
    test_beyond_cfg();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time limit in case the sequence stalls.
  initial begin
    #20000;
    $display("FAIL timeout reached at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $finish;
  end

endmodule

// File: doc/sobel_row_window.md
Name: sobel_row_window

Overview:
- Upstream neighbour of the Sobel accelerator core.
- Accepts one image-row word per handshake from the memory read path and keeps a 3-row sliding window (row1 = oldest, row3 = newest).
- Presents the window to the accelerator core with a valid/ready handshake.
- Tracks position within a column strip and flags the last window of each strip so the write controller can advance.

Parameters:
- NUM_ACC, 8, number of accelerator cores; each output pixel uses one core.
- IW, (NUM_ACC+2)*8, row word width in bits; equals `SOBEL_IDATA_WIDTH.
- ROWW, 10, width of the row-count configuration and internal row counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cfg_rows  input  ROWW  image rows per strip; sampled on each accepted in_first row.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  IW  one row word; byte 0 = rightmost pixel.
- in_first  input  1  qualifies in_data as the first row of a new strip.
- out_valid  output  1  window rows are valid.
- out_ready  input  1  accelerator/write stage consumes the window.
- row1_data  output  IW  oldest row (drives srow2sacc_row1_data).
- row2_data  output  IW  middle row.
- row3_data  output  IW  newest row.
- out_last  output  1  current window is the final window of the strip.

Behaviour:
- Reset (asynchronous, active-high): row1/2/3_data = 0, out_valid = 0, out_last = 0, fill count = 0, row counter = 0, state = EMPTY.
- in_ready = !out_valid || out_ready (combinational). An input is accepted on in_valid && in_ready; a window is consumed on out_valid && out_ready.
- States, indexed by fill count:
  - EMPTY(0)
  - ONE(1)
  - TWO(2)
  - FULL(3)
- Accept, in_first = 0, state not FULL: row1 <= row2, row2 <= row3, row3 <= in_data; fill count +1. Entering FULL sets out_valid = 1 on the next cycle (1-cycle latency from the third accept).
- Accept, in_first = 0, state FULL: same shift; out_valid = 1 next cycle.
- Consume without accept: out_valid <= 0. Rows hold; state stays FULL and the same window is not re-presented.
- Simultaneous consume and accept: shift occurs, out_valid stays 1, no bubble. Throughput is 1 window/cycle after priming.
- Accept with in_first = 1, from any state:
  - row1 = row2 = 0, row3 <= in_data, fill count = 1 (state ONE).
  - Row counter = 1; out_valid <= 0; cfg_rows latched.
  - Any unconsumed window is discarded.
- Row counter: increments on every non-first accept and saturates at 2^ROWW-1. It counts rows loaded in the current strip.
- out_last = out_valid && (row counter == latched cfg_rows). It is registered together with the rows.
- Latched cfg_rows < 3: no window is ever produced for that strip; all rows are accepted and shifted, out_valid stays 0.
- Rows accepted beyond cfg_rows still form windows; out_last stays 0 for them. The counter saturates and does not wrap.
- in_valid with in_ready = 0: in_data is ignored. The upstream must hold it.
- Reset asserted mid-strip: everything returns to reset values immediately. The first row accepted after reset without in_first is treated as row 1 of an unnamed strip, with latched cfg_rows = 0, so out_last never fires.
- All outputs are registered except in_ready.

Optional Feature:
- Macro: SOBEL_WINDOW_STALL_CNT_EN.
- Enabled:
  - Adds output port stall_count [15:0], a counter of cycles with out_valid && !out_ready.
  - Saturates at 16'hFFFF; cleared by reset and by any accepted in_first row.
  - Reset value 0.
- Disabled: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Prime: cfg_rows = 5, NUM_ACC = 8; send rows A (in_first), B, C with out_ready = 1 -> out_valid rises the cycle after C is accepted, with row1 = A, row2 = B, row3 = C, out_last = 0.
- Streaming: continue D, E back-to-back with out_ready = 1 -> windows (B,C,D) then (C,D,E) on consecutive cycles; out_last = 1 only on (C,D,E); in_ready stays 1 throughout.
- Backpressure: hold out_ready = 0 while window (A,B,C) is valid and offer D -> in_ready = 0, rows stable. Raise out_ready -> D is accepted the same cycle and (B,C,D) appears next cycle. With STALL_CNT_EN, stall_count equals the number of held cycles.
- Strip restart: with window (B,C,D) valid and unconsumed, accept X with in_first = 1 -> next cycle out_valid = 0, row1 = row2 = 0, row3 = X. A window appears only after two more rows.
- Short strip: cfg_rows = 2, send in_first row then one more row -> out_valid never asserts.
- Async reset: assert reset between clock edges while FULL -> out_valid, rows and out_last go to 0 before the next clk edge; in_ready = 1 after release.
